// File: rtl/reg_file_pkg.sv
// Shared core constants and register-file state encoding.
// Imported by the register file and its scrub controller.
package reg_file_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int REG_ZERO = 0;

   typedef enum logic {
      RF_SCRUB = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_scrub_ctrl.sv
// Post-reset scrub FSM and write-port mux for the register file.
// Zeroes x1..x(NREGS-1) one per cycle, then hands the port to the core.
module rf_scrub_ctrl
   import reg_file_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int NREGS = 32,
   parameter int AW    = REG_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             run,
   output logic             ready,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

   rf_state_t       state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            ready_q, ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_SCRUB;
         ptr_q   <= AW'(1);
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      ready_d   = ready_q;
      mem_we    = 1'b0;
      mem_addr  = rd_addr;
      mem_wdata = wdata;
      unique case (state_q)
         RF_SCRUB: begin
            // External writes are dropped here, not queued
            ptr_d     = ptr_q + AW'(1);
            mem_we    = ~rst;
            mem_addr  = ptr_q;
            mem_wdata = '0;
            if (ptr_q == LAST) begin
               state_d = RF_RUN;
               ready_d = 1'b1;
            end
         end
         RF_RUN: begin
            mem_we = we & ~rst & (rd_addr != ZERO);
         end
         default: begin
            state_d = RF_SCRUB;
         end
      endcase
   end

   assign run   = (state_q == RF_RUN);
   assign ready = ready_q;

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: two combinational read ports,
// one write port, x0 hardwired to zero, optional write-to-read bypass.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = XLEN,
   parameter int NREGS  = 32,
   parameter int AW     = REG_AW,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             ready
);

   localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

   logic [WIDTH-1:0] mem [NREGS];
   logic             run;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             fwd1, fwd2;

   rf_scrub_ctrl #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scrub (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .rd_addr   (rd_addr),
      .wdata     (wdata),
      .run       (run),
      .ready     (ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

   // No reset on the array so it can map to distributed RAM
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign fwd1 = (BYPASS != 0) && we && (rd_addr == rs1_addr);
   assign fwd2 = (BYPASS != 0) && we && (rd_addr == rs2_addr);

   always_comb begin
      rd1 = '0;
      if (run && (rs1_addr != ZERO)) begin
         rd1 = fwd1 ? wdata : mem[rs1_addr];
      end
   end

   always_comb begin
      rd2 = '0;
      if (run && (rs2_addr != ZERO)) begin
         rd2 = fwd2 ? wdata : mem[rs2_addr];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Instantiates a bypass and a non-bypass copy on the same inputs.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rd1, rd2;
   logic [31:0] nb_rd1, nb_rd2;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] wdata;
   logic        ready, nb_ready;

   int checks;
   int errors;

   reg_file #(.BYPASS(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd1      (rd1),
      .rd2      (rd2),
      .we       (we),
      .rd_addr  (rd_addr),
      .wdata    (wdata),
      .ready    (ready)
   );

   reg_file #(.BYPASS(0)) dut_nb (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd1      (nb_rd1),
      .rd2      (nb_rd2),
      .we       (we),
      .rd_addr  (rd_addr),
      .wdata    (wdata),
      .ready    (nb_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      we      = 1'b1;
      rd_addr = a;
      wdata   = d;
      tick();
      we      = 1'b0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      we       = 1'b0;
      rd_addr  = 5'd0;
      wdata    = 32'h0;
      rs1_addr = 5'd5;
      rs2_addr = 5'd9;
      tick();
      tick();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %0b want 0", ready);
      end
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd got %h/%h want 0/0", rd1, rd2);
      end
      rst = 1'b0;
   endtask

   task automatic test_scrub;
      for (int e = 1; e <= 31; e++) begin
         rs1_addr = 5'(e);
         rs2_addr = 5'd31;
         if (e == 10) begin
            we      = 1'b1;
            rd_addr = 5'd3;
            wdata   = 32'hFFFF_FFFF;
            rs1_addr = 5'd3;
            #1;
            checks++;
            if (rd1 !== 32'h0) begin
               errors++;
               $display("FAIL scrub_nofwd got %h want 0", rd1);
            end
         end
         tick();
         we = 1'b0;
         if (e <= 30) begin
            checks++;
            if (ready !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
               errors++;
               $display("FAIL scrub_edge%0d rdy %0b rd %h/%h want 0", e, ready, rd1, rd2);
            end
         end else begin
            checks++;
            if (ready !== 1'b1 || nb_ready !== 1'b1) begin
               errors++;
               $display("FAIL scrub_done rdy %0b/%0b want 1/1", ready, nb_ready);
            end
         end
      end
      for (int r = 1; r < 32; r++) begin
         rs1_addr = 5'(r);
         rs2_addr = 5'(r);
         #1;
         checks++;
         if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++;
            $display("FAIL scrub_zero x%0d got %h/%h want 0", r, rd1, rd2);
         end
      end
   endtask

   task automatic test_write_read;
      do_write(5'd5, 32'hDEAD_BEEF);
      rs2_addr = 5'd5;
      #1;
      checks++;
      if (rd2 !== 32'hDEAD_BEEF || nb_rd2 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wr_x5 got %h/%h want deadbeef", rd2, nb_rd2);
      end
      we       = 1'b1;
      rd_addr  = 5'd0;
      wdata    = 32'h1234_5678;
      rs1_addr = 5'd0;
      #1;
      checks++;
      if (rd1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_fwd got %h want 0", rd1);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rd1 !== 32'h0 || nb_rd1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_wr got %h/%h want 0", rd1, nb_rd1);
      end
   endtask

   task automatic test_bypass;
      do_write(5'd7, 32'h1111_1111);
      we       = 1'b1;
      rd_addr  = 5'd7;
      wdata    = 32'hA5A5_A5A5;
      rs1_addr = 5'd7;
      rs2_addr = 5'd7;
      #1;
      checks++;
      if (rd1 !== 32'hA5A5_A5A5 || rd2 !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL byp_on got %h/%h want a5a5a5a5", rd1, rd2);
      end
      checks++;
      if (nb_rd1 !== 32'h1111_1111 || nb_rd2 !== 32'h1111_1111) begin
         errors++;
         $display("FAIL byp_off got %h/%h want 11111111", nb_rd1, nb_rd2);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rd1 !== 32'hA5A5_A5A5 || nb_rd2 !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL byp_after got %h/%h want a5a5a5a5", rd1, nb_rd2);
      end
   endtask

   task automatic test_reset_mid_scrub;
      int n;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 15; e++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n != 31) begin
         errors++;
         $display("FAIL rescrub_latency got %0d edges want 31", n);
      end
   endtask

   task automatic test_fill_rescrub;
      logic [31:0] v;
      for (int r = 1; r < 32; r++) begin
         v = 32'(r) * 32'h0101_0101;
         do_write(5'(r), v);
      end
      for (int r = 1; r < 32; r++) begin
         v = 32'(r) * 32'h0101_0101;
         rs1_addr = 5'(r);
         rs2_addr = 5'(32 - r);
         #1;
         checks++;
         if (rd1 !== v) begin
            errors++;
            $display("FAIL fill_x%0d got %h want %h", r, rd1, v);
         end
      end
      rst = 1'b1;
      we      = 1'b1;
      rd_addr = 5'd2;
      wdata   = 32'hCAFE_F00D;
      tick();
      rst = 1'b0;
      we  = 1'b0;
      for (int e = 1; e <= 31; e++) tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_ready got %0b want 1", ready);
      end
      for (int r = 1; r < 32; r++) begin
         rs1_addr = 5'(r);
         rs2_addr = 5'(r);
         #1;
         checks++;
         if (rd1 !== 32'h0 || nb_rd2 !== 32'h0) begin
            errors++;
            $display("FAIL clr_x%0d got %h/%h want 0", r, rd1, nb_rd2);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_scrub();
      test_write_read();
      test_bypass();
      test_reset_mid_scrub();
      test_fill_rescrub();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
